mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
//
// PURPOSE
// Shares the single-port 20-bit word RAM between NUM_REQ requesters: the lisp core, a host loader/debug port and a display DMA.
// Fair round-robin arbitration, one access per cycle, with an optional lock for read-modify-write sequences.
// Returns read data with the RAM's fixed 1-cycle latency, tagged to the requester that issued the read.
// Sits between the requesters and the memory instance; the hardware-register window stays decoded in the core.
//
// PARAMETERS
// NUM_REQ     2   number of requesters (1..8); index 0 is the lisp core
// ADDR_WIDTH  16  word address width
// DATA_WIDTH  20  word width (4-bit tag + 16-bit value)
// MAX_LOCK    8   max consecutive grants held by one locked requester before forced release
//
// PORTS
// clk          in   1                     clock, all state on rising edge
// reset_n      in   1                     asynchronous active-low reset
// req_i        in   NUM_REQ               per-requester access request, held until granted
// lock_i       in   NUM_REQ               requester asks to keep the grant next cycle
// write_i      in   NUM_REQ               1 = write, 0 = read
// addr_i       in   NUM_REQ*ADDR_WIDTH    packed addresses, requester k at [k*ADDR_WIDTH +: ADDR_WIDTH]
// wdata_i      in   NUM_REQ*DATA_WIDTH    packed write data, same packing
// grant_o      out  NUM_REQ               one-hot; access accepted this cycle
// rvalid_o     out  NUM_REQ               one-hot; rdata_o holds read data for that requester
// rdata_o      out  DATA_WIDTH            read data, shared by all requesters
// mem_addr_o   out  ADDR_WIDTH            to RAM addr_i
// mem_wdata_o  out  DATA_WIDTH            to RAM value_i
// mem_write_o  out  1                     to RAM write_i
// mem_rdata_i  in   DATA_WIDTH            from RAM value_o
//
// BEHAVIOUR
// - Reset: grant_o=0, rvalid_o=0, mem_write_o=0, mem_addr_o=0, mem_wdata_o=0, rr pointer=0, lock owner none, lock count=0.
// - Grant is combinational in the same cycle. mem_* show the winner's addr, wdata and write. With no winner, mem_write_o=0 and addr/wdata=0.
// - Round-robin: search starts at (last winner+1) mod NUM_REQ. The pointer updates only on a grant.
// - Lock: if the winner has lock_i=1, it owns the port. While it keeps req_i=1, it is the only requester granted.
// - Lock count: increments per locked grant. When it reaches MAX_LOCK, ownership drops, other requesters are searched first, and the count clears.
// - Lock release: the owner deasserting req_i or lock_i releases the port that cycle, and arbitration resumes round-robin.
// - Read latency: a granted read gives rvalid_o[k]=1 on the next cycle, with rdata_o=mem_rdata_i.
// - Writes never produce rvalid. Back-to-back reads by different requesters are pipelined, one per cycle.
// - Same-cycle requests: exactly one grant. Requesters not granted must hold req/addr/wdata/write stable.
// - Read after write to the same address: the write must complete first, so the read returns the new data (RAM is write-first).
// - Requester deasserts req in the same cycle it is granted: allowed, the grant still counts.
// - A lock_i without req_i is ignored.
// - Reset mid-operation clears all state, and a pending rvalid is lost. Requesters must reissue.
// - Width: NUM_REQ=1 degenerates to a pass-through: grant_o=req_i and a 1-cycle rvalid.
//
// STRUCTURE
// - Shared include lisp_mem_defs.vh holds the DATA_WIDTH/ADDR_WIDTH defaults, the tag field position [19:16], and the requester index constants REQ_CORE=0, REQ_HOST=1, REQ_DMA=2.
// - One sub-module, rr_picker: combinational rotate-priority one-hot select from a request vector and a start index.
// - Top level contains the pointer, lock owner and counter, the rvalid pipeline register and the mem mux.
//
// TESTING
// - Reset: hold reset_n=0 with random req. grant_o, rvalid_o and mem_write_o stay 0. Deassert; the first request from 1 alone is granted the same cycle.
// - Contention: req_i=2'b11 continuously, both reads. Grants alternate 01,10,01,... and each rvalid follows its grant by exactly 1 cycle.
// - Read latency: req1 writes 0x5A5A5 to addr 0x0100, then req0 reads 0x0100 next cycle. rvalid_o=01 one cycle later with rdata_o=0x5A5A5.
// - Lock: req0 holds lock_i=1 with req1 pending, MAX_LOCK=8. req0 is granted 8 consecutive cycles, req1 is granted on cycle 9, then round-robin resumes.
// - Early release: req0 locked, drops lock_i after 3 grants. req1 is granted on the 4th cycle and the lock count reads 0.
// - Mid-op reset: reset_n pulses low on the cycle after a granted read. No rvalid appears, and the pointer restarts at 0 (req 0 wins a 2'b11 tie).

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared defaults for the word-RAM port arbiter: bus widths, tag field and requester indices.
package mem_port_arbiter_pkg;

  localparam int DEF_NUM_REQ    = 2;
  localparam int DEF_ADDR_WIDTH = 16;
  localparam int DEF_DATA_WIDTH = 20;
  localparam int DEF_MAX_LOCK   = 8;

  // 20-bit word = 4-bit type tag over a 16-bit value
  localparam int TAG_MSB = 19;
  localparam int TAG_LSB = 16;

  localparam int REQ_CORE = 0;
  localparam int REQ_HOST = 1;
  localparam int REQ_DMA  = 2;

  function automatic int next_idx(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester-side and RAM-side bundle of the arbiter; slave is the arbiter view, master the surroundings.
interface mem_port_arbiter_if
  import mem_port_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
  logic [NUM_REQ-1:0]            req_i;
  logic [NUM_REQ-1:0]            lock_i;
  logic [NUM_REQ-1:0]            write_i;
  logic [NUM_REQ*ADDR_WIDTH-1:0] addr_i;
  logic [NUM_REQ*DATA_WIDTH-1:0] wdata_i;
  logic [NUM_REQ-1:0]            grant_o;
  logic [NUM_REQ-1:0]            rvalid_o;
  logic [DATA_WIDTH-1:0]         rdata_o;
  logic [ADDR_WIDTH-1:0]         mem_addr_o;
  logic [DATA_WIDTH-1:0]         mem_wdata_o;
  logic                          mem_write_o;
  logic [DATA_WIDTH-1:0]         mem_rdata_i;

  modport slave (
    input  req_i, lock_i, write_i, addr_i, wdata_i, mem_rdata_i,
    output grant_o, rvalid_o, rdata_o, mem_addr_o, mem_wdata_o, mem_write_o
  );

  modport master (
    output req_i, lock_i, write_i, addr_i, wdata_i, mem_rdata_i,
    input  grant_o, rvalid_o, rdata_o, mem_addr_o, mem_wdata_o, mem_write_o
  );
endinterface

// File: rtl/mem_port_arbiter_rr_picker.sv
// Rotate-priority one-hot select: first set request at or after start, wrapping; purely combinational.
module mem_port_arbiter_rr_picker #(
  parameter int N  = 2,
  parameter int PW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] start,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx,
  output logic          any
);

  always_comb begin
    int k;
    k   = 0;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int i = 0; i < N; i++) begin
      k = int'(start) + i;
      if (k >= N) k = k - N;
      if (!any && req[k]) begin
        any = 1'b1;
        idx = PW'(k);
      end
    end
    if (any) gnt[idx] = 1'b1;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin single-port RAM arbiter with bounded lock; same-cycle grant, read data 1 cycle later.
// Losers simply wait: requesters hold req/addr/wdata until their grant cycle.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MAX_LOCK   = DEF_MAX_LOCK
) (
  input logic clk,
  input logic reset_n,
  mem_port_arbiter_if.slave bus
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(MAX_LOCK + 1);

  logic [PW-1:0]      ptr_q;
  logic [PW-1:0]      owner_q;
  logic               owner_vld_q;
  logic [CW-1:0]      lock_cnt_q;
  logic [NUM_REQ-1:0] rvalid_q;

  logic [NUM_REQ-1:0] pick_gnt;
  logic [PW-1:0]      pick_idx;
  logic               pick_any;
  logic               owner_active;
  logic [NUM_REQ-1:0] grant;
  logic [PW-1:0]      win_idx;
  logic               win_any;
  logic [CW-1:0]      cnt_inc;

  mem_port_arbiter_rr_picker #(.N(NUM_REQ), .PW(PW)) u_picker (
    .req   (bus.req_i),
    .start (ptr_q),
    .gnt   (pick_gnt),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // Owner keeps the port only while it still asserts both req and lock.
  assign owner_active = owner_vld_q && bus.req_i[owner_q] && bus.lock_i[owner_q];
  assign cnt_inc      = (owner_active ? lock_cnt_q : '0) + CW'(1);

  always_comb begin
    grant   = pick_gnt;
    win_idx = pick_idx;
    win_any = pick_any;
    if (owner_active) begin
      grant          = '0;
      grant[owner_q] = 1'b1;
      win_idx        = owner_q;
      win_any        = 1'b1;
    end
    if (!reset_n) begin
      grant   = '0;
      win_any = 1'b0;
    end
  end

  assign bus.grant_o     = grant;
  assign bus.rvalid_o    = rvalid_q;
  assign bus.rdata_o     = bus.mem_rdata_i;
  assign bus.mem_write_o = win_any & bus.write_i[win_idx];
  assign bus.mem_addr_o  = win_any ? bus.addr_i[win_idx*ADDR_WIDTH +: ADDR_WIDTH] : '0;
  assign bus.mem_wdata_o = win_any ? bus.wdata_i[win_idx*DATA_WIDTH +: DATA_WIDTH] : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q       <= '0;
      owner_q     <= '0;
      owner_vld_q <= 1'b0;
      lock_cnt_q  <= '0;
      rvalid_q    <= '0;
    end else begin
      rvalid_q    <= grant & ~bus.write_i;
      owner_vld_q <= 1'b0;
      lock_cnt_q  <= '0;
      if (win_any) begin
        // Pointer moves past the winner, so a forced release hands priority to the others.
        ptr_q <= PW'(next_idx(int'(win_idx), NUM_REQ));
        if (bus.lock_i[win_idx] && cnt_inc != CW'(MAX_LOCK)) begin
          owner_vld_q <= 1'b1;
          owner_q     <= win_idx;
          lock_cnt_q  <= cnt_inc;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a write-first 1-cycle RAM model; two requesters.
module tb_mem_port_arbiter;

  logic clk;
  logic reset_n;
  int   total;
  int   bad;

  mem_port_arbiter_if #(.NUM_REQ(2), .ADDR_WIDTH(16), .DATA_WIDTH(20)) bus ();

  mem_port_arbiter #(.NUM_REQ(2), .ADDR_WIDTH(16), .DATA_WIDTH(20), .MAX_LOCK(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [19:0] ram [0:65535];
  always @(posedge clk) begin
    if (bus.mem_write_o) ram[bus.mem_addr_o] <= bus.mem_wdata_o;
    bus.mem_rdata_i <= bus.mem_write_o ? bus.mem_wdata_o : ram[bus.mem_addr_o];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [1:0] r, input logic [1:0] l, input logic [1:0] w,
                       input logic [15:0] a0, input logic [15:0] a1, input logic [19:0] d1);
    @(negedge clk);
    bus.req_i   = r;
    bus.lock_i  = l;
    bus.write_i = w;
    bus.addr_i  = {a1, a0};
    bus.wdata_i = {d1, 20'h0};
    #1;
  endtask

  initial begin
    logic [1:0] exp_g;
    logic [1:0] prev_g;
    total       = 0;
    bad         = 0;
    reset_n     = 1'b0;
    bus.req_i   = '0;
    bus.lock_i  = '0;
    bus.write_i = '0;
    bus.addr_i  = '0;
    bus.wdata_i = '0;

    // Reset held with random traffic
    for (int i = 0; i < 3; i++) begin
      drive(2'($urandom), 2'($urandom), 2'($urandom), 16'h0011, 16'h0022, 20'h12345);
      check("rst_grant", 32'(bus.grant_o), 32'h0);
      check("rst_rvalid", 32'(bus.rvalid_o), 32'h0);
      check("rst_mwrite", 32'(bus.mem_write_o), 32'h0);
    end

    @(negedge clk);
    reset_n     = 1'b1;
    bus.req_i   = 2'b10;
    bus.lock_i  = 2'b00;
    bus.write_i = 2'b00;
    bus.addr_i  = {16'h0042, 16'h0000};
    #1;
    check("first_grant", 32'(bus.grant_o), 32'h2);
    check("first_addr", 32'(bus.mem_addr_o), 32'h42);

    drive(2'b00, 2'b00, 2'b00, 16'h0000, 16'h0000, 20'h0);
    check("first_rvalid", 32'(bus.rvalid_o), 32'h2);
    check("idle_grant", 32'(bus.grant_o), 32'h0);
    check("idle_addr", 32'(bus.mem_addr_o), 32'h0);
    check("idle_wdata", 32'(bus.mem_wdata_o), 32'h0);
    check("idle_mwrite", 32'(bus.mem_write_o), 32'h0);

    // Contention: both read every cycle
    prev_g = 2'b00;
    for (int i = 0; i < 6; i++) begin
      drive(2'b11, 2'b00, 2'b00, 16'h0010, 16'h0020, 20'h0);
      exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
      check("cont_grant", 32'(bus.grant_o), 32'(exp_g));
      check("cont_rvalid", 32'(bus.rvalid_o), 32'(prev_g));
      prev_g = exp_g;
    end

    // Write by req1 then read-back by req0
    drive(2'b10, 2'b00, 2'b10, 16'h0000, 16'h0100, 20'h5A5A5);
    check("wr_grant", 32'(bus.grant_o), 32'h2);
    check("wr_rvalid_tail", 32'(bus.rvalid_o), 32'h2);
    check("wr_mwrite", 32'(bus.mem_write_o), 32'h1);
    check("wr_maddr", 32'(bus.mem_addr_o), 32'h100);
    check("wr_mwdata", 32'(bus.mem_wdata_o), 32'h5A5A5);
    drive(2'b01, 2'b00, 2'b00, 16'h0100, 16'h0000, 20'h0);
    check("rd_grant", 32'(bus.grant_o), 32'h1);
    check("rd_no_rvalid_after_wr", 32'(bus.rvalid_o), 32'h0);
    check("rd_maddr", 32'(bus.mem_addr_o), 32'h100);
    drive(2'b00, 2'b00, 2'b00, 16'h0000, 16'h0000, 20'h0);
    check("rd_rvalid", 32'(bus.rvalid_o), 32'h1);
    check("rd_rdata", 32'(bus.rdata_o), 32'h5A5A5);

    // Lock: req0 holds for MAX_LOCK grants, then req1 gets through
    drive(2'b01, 2'b01, 2'b00, 16'h0000, 16'h0000, 20'h0);
    check("lock_g1", 32'(bus.grant_o), 32'h1);
    for (int i = 2; i <= 8; i++) begin
      drive(2'b11, 2'b01, 2'b00, 16'h0000, 16'h0000, 20'h0);
      check("lock_hold", 32'(bus.grant_o), 32'h1);
    end
    drive(2'b11, 2'b01, 2'b00, 16'h0000, 16'h0000, 20'h0);
    check("lock_forced_release", 32'(bus.grant_o), 32'h2);
    drive(2'b11, 2'b01, 2'b00, 16'h0000, 16'h0000, 20'h0);
    check("lock_rr_resume", 32'(bus.grant_o), 32'h1);
    drive(2'b00, 2'b00, 2'b00, 16'h0000, 16'h0000, 20'h0);
    check("lock_idle", 32'(bus.grant_o), 32'h0);

    // Early release after 3 locked grants
    drive(2'b01, 2'b01, 2'b00, 16'h0000, 16'h0000, 20'h0);
    check("early_g1", 32'(bus.grant_o), 32'h1);
    drive(2'b11, 2'b01, 2'b00, 16'h0000, 16'h0000, 20'h0);
    check("early_g2", 32'(bus.grant_o), 32'h1);
    drive(2'b11, 2'b01, 2'b00, 16'h0000, 16'h0000, 20'h0);
    check("early_g3", 32'(bus.grant_o), 32'h1);
    drive(2'b11, 2'b00, 2'b00, 16'h0000, 16'h0000, 20'h0);
    check("early_cnt3", 32'(dut.lock_cnt_q), 32'h3);
    check("early_g4", 32'(bus.grant_o), 32'h2);
    drive(2'b00, 2'b00, 2'b00, 16'h0000, 16'h0000, 20'h0);
    check("early_cnt0", 32'(dut.lock_cnt_q), 32'h0);

    // Reset right after a granted read
    drive(2'b01, 2'b00, 2'b00, 16'h0033, 16'h0000, 20'h0);
    check("mid_grant", 32'(bus.grant_o), 32'h1);
    @(negedge clk);
    reset_n   = 1'b0;
    bus.req_i = 2'b00;
    #1;
    check("mid_rvalid_lost", 32'(bus.rvalid_o), 32'h0);
    check("mid_rst_grant", 32'(bus.grant_o), 32'h0);
    @(negedge clk);
    reset_n   = 1'b1;
    bus.req_i = 2'b11;
    #1;
    check("mid_ptr_restart", 32'(bus.grant_o), 32'h1);
    drive(2'b11, 2'b00, 2'b00, 16'h0000, 16'h0000, 20'h0);
    check("mid_next_grant", 32'(bus.grant_o), 32'h2);
    check("mid_next_rvalid", 32'(bus.rvalid_o), 32'h1);
    drive(2'b00, 2'b00, 2'b00, 16'h0000, 16'h0000, 20'h0);
    check("mid_last_rvalid", 32'(bus.rvalid_o), 32'h2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
